// File: rtl/pa_spsram_45b_acc_ctrl.sv
// rtl/pa_spsram_45b_acc_ctrl.sv - requester-side access controller for the 64x45 single-port SRAM
// Owns all SRAM pins: clears the array after reset or on request, then serves masked writes and reads.
module pa_spsram_45b_acc_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 45
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rdata_vld,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    rd_pend;
    logic [DATA_WIDTH-1:0]   rdata_hold;
    logic                    accept;

    // init_req only matters in RUN; a clear in progress always runs to the last entry
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state   <= ST_RST;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_RST: begin
                    state   <= ST_INIT;
                    clr_cnt <= '0;
                end
                ST_INIT: begin
                    if (clr_cnt == LAST_ENTRY) begin
                        state <= ST_RUN;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state   <= ST_INIT;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_RST;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    assign req_rdy   = (state == ST_RUN) && !init_req;
    assign accept    = req_vld && req_rdy;
    assign init_busy = (state != ST_RUN);

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (state == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = clr_cnt;
        end else if (accept) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            sram_d   = req_wdata;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
            end
        end
    end

    // Read data arrives one cycle after accept; the hold copy serves late samplers
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_pend    <= 1'b0;
            rdata_hold <= '0;
        end else begin
            rd_pend <= accept && !req_wr;
            if (rd_pend) begin
                rdata_hold <= sram_q;
            end
        end
    end

    assign rdata_vld = rd_pend;
    assign rdata     = rd_pend ? sram_q : rdata_hold;

endmodule

// File: doc/pa_spsram_45b_acc_ctrl.md
# pa_spsram_45b_acc_ctrl

Requester-side access controller for the 64x45 single-port FPGA SRAM model (active-low CEN/GWEN/per-bit WEN, synchronous read). The block sits directly upstream of the SRAM. It owns every SRAM pin, clears the array after reset or on request, and arbitrates a valid/ready request port for bit-masked writes and reads. It returns read data with a valid strobe and holds the last read value for consumers that sample late.

## Interface
Parameters:
- ADDR_WIDTH, 6, SRAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 45, SRAM word width.

Ports:
- forever_cpuclk  in  1  single clock; all state updates on its rising edge.
- cpurst_b  in  1  reset, asynchronous and active-low.
- init_req  in  1  pulse; requests a full array clear.
- init_busy  out  1  high while a clear is pending or in progress.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  entry index.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  1 = write this bit.
- rdata_vld  out  1  single-cycle read-return strobe.
- rdata  out  DATA_WIDTH  read data.
- sram_a  out  ADDR_WIDTH  SRAM address.
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_gwen  out  1  SRAM global write enable, active-low.
- sram_wen  out  DATA_WIDTH  SRAM per-bit write enable, active-low.
- sram_d  out  DATA_WIDTH  SRAM write data.
- sram_q  in  DATA_WIDTH  SRAM read data.

## Operation
- FSM states: RST, INIT, RUN. Reset forces RST.
  - RST -> INIT unconditionally on the next edge.
  - INIT -> RUN after the write to entry depth-1.
  - RUN -> INIT when init_req=1.
  - init_req is ignored in RST and INIT. It does not restart a clear in progress.
- Clear counter: ADDR_WIDTH bits. Set to 0 on entry to INIT; increments by 1 each INIT cycle. The terminal value depth-1 triggers the INIT -> RUN transition; the counter never wraps inside INIT.
- SRAM drive in INIT: sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=counter.
- SRAM drive in RUN on an accepted request: sram_cen=0, sram_a=req_addr, sram_d=req_wdata.
  - Write: sram_gwen=0 and sram_wen=~req_wmask.
  - Read: sram_gwen=1 and sram_wen=all 1.
- SRAM drive otherwise (RST, or RUN with no accept): sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- All SRAM outputs are combinational from state, counter and request fields. No extra pipeline stage is inserted.
- req_rdy = (state==RUN) & ~init_req. This is combinational; init wins a same-cycle collision, and that request is not accepted.
- A write with req_wmask=0 is still accepted and drives CEN low. No SRAM bit changes.
- Read return:
  - Flop rd_pend is set on an accepted read and cleared otherwise.
  - rdata_vld = rd_pend.
  - rdata = rd_pend ? sram_q : rdata_hold.
  - rdata_hold captures sram_q on every edge where rd_pend=1.
- No backpressure on the read return; the consumer must take rdata on rdata_vld.
- Back-to-back reads are legal, one per cycle. A read that follows a write to the same address returns the new data.
- init_busy = (state != RUN).
- A read accepted in the cycle before RUN -> INIT still returns normally in the next cycle.

## Timing
- Reset values, all outputs while cpurst_b=0:
  - req_rdy=0, init_busy=1, rdata_vld=0, rdata=0.
  - sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- C0 is the first cycle with cpurst_b=1; state is RST, sram_cen=1.
- Cycles C1..C64 are INIT, writing 0 to addresses 0..63.
- C65: RUN, req_rdy=1 and init_busy=0.
- A clear triggered by init_req in cycle N:
  - INIT occupies N+1..N+64.
  - req_rdy is high again at N+65.
- Read latency: accept in cycle N -> rdata_vld=1 with valid rdata in N+1 -> rdata_hold keeps that value from N+2 onward.
- Write latency: the SRAM is updated at the edge ending the accept cycle.
- Throughput: one request per cycle in RUN.
- Reset asserted mid-INIT or mid-read:
  - All state clears immediately and rd_pend drops.
  - The full clear sequence restarts after release.

## Test plan
- Reset release: after 65 cycles req_rdy=1. Over C1..C64, sram_cen=0 with sram_a sequencing 0..63 and sram_d=0. A subsequent read of address 37 returns 0 with rdata_vld in the next cycle.
- Masked write: write 45'h1F_FFFF_FFFF_FF to address 5 with mask all 1, then write 0 with mask 45'h0000_0000_00FF. A read of address 5 returns 45'h1F_FFFF_FFFF_00.
- Back-to-back traffic: reads of addresses 1, 2, 3 on consecutive cycles after writes of 0xA, 0xB, 0xC. Required: rdata_vld high for 3 cycles carrying 0xA, 0xB, 0xC. rdata then holds 0xC with rdata_vld=0.
- Collision: init_req and req_vld asserted in the same RUN cycle. Required: the request is not accepted; init_busy=1 for 64 cycles; every entry reads back 0 afterwards.
- Reset mid-INIT: cpurst_b pulsed low at C30. Required: outputs return to reset values immediately; after release the sweep starts again from address 0 and RUN is reached 65 cycles later.
- Zero-mask write: address 9 holds 0x123; write with mask 0. Required: sram_cen=0 and sram_wen all 1 that cycle; a read of address 9 returns 0x123.
